load_store_unit: RTL and testbench

Pipeline-side initiator for the word-addressed data memory: takes one load or store per handshake from the EX/MEM stage and drives `data_address`, `data`, `MemRead` and `MemWrite` to the memory. It captures `MemOut` and returns an extended load result, or a store completion, to MEM/WB. Byte and halfword stores become read-modify-write sequences, because the memory only writes whole words. The unit holds `stall` high while an access is in flight.

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit bridging EX/MEM requests to a word-addressed data memory,
// with read-modify-write for sub-word stores. Optional macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] data_address,
   output logic [31:0] data,
   output logic        MemRead,
   output logic        MemWrite,
   input  logic [31:0] MemOut,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        stall
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t      state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        write_q;
   logic        signed_q;
   logic [3:0]  cnt;
   logic        misaligned;

   // Right-align the addressed lane and extend it to 32 bits
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (size)
         2'b00:   return {{24{sgn & b[7]}}, b};
         2'b01:   return {{16{sgn & h[15]}}, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] off);
      logic [31:0] m;
      m = word;
      case (size)
         2'b00:   m[{off, 3'b000} +: 8]    = wd[7:0];
         2'b01:   m[{off[1], 4'b0000} +: 16] = wd[15:0];
         default: m = wd;
      endcase
      return m;
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return off[0];
         default: return (off != 2'b00);
      endcase
   endfunction

   assign misaligned = is_misaligned(req_size, req_addr[1:0]);
`else
   // Unchecked: the lane selectors below simply ignore the low address bits
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         size_q       <= 2'b00;
         write_q      <= 1'b0;
         signed_q     <= 1'b0;
         cnt          <= 4'd0;
         req_ready    <= 1'b1;
         stall        <= 1'b0;
         MemRead      <= 1'b0;
         MemWrite     <= 1'b0;
         data_address <= 32'd0;
         data         <= 32'd0;
         resp_valid   <= 1'b0;
         resp_rdata   <= 32'd0;
         resp_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  size_q    <= req_size;
                  write_q   <= req_write;
                  signed_q  <= req_signed;
                  req_ready <= 1'b0;
                  stall     <= 1'b1;
                  if (misaligned) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (req_write && req_size[1]) begin
                     state        <= WRITE;
                     MemWrite     <= 1'b1;
                     data_address <= {2'b00, req_addr[31:2]};
                     data         <= req_wdata;
                  end else begin
                     state        <= READ;
                     MemRead      <= 1'b1;
                     data_address <= {2'b00, req_addr[31:2]};
                     cnt          <= LAT_M1;
                  end
               end
            end
            READ: begin
               if (cnt == 4'd0) begin
                  MemRead <= 1'b0;
                  if (write_q) begin
                     state        <= WRITE;
                     MemWrite     <= 1'b1;
                     data_address <= {2'b00, addr_q[31:2]};
                     data         <= merge_lane(MemOut, wdata_q, size_q, addr_q[1:0]);
                  end else begin
                     state        <= RESP;
                     data_address <= 32'd0;
                     resp_valid   <= 1'b1;
                     resp_rdata   <= load_extend(MemOut, size_q, addr_q[1:0], signed_q);
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            WRITE: begin
               state        <= RESP;
               MemWrite     <= 1'b0;
               data_address <= 32'd0;
               data         <= 32'd0;
               resp_valid   <= 1'b1;
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_rdata <= 32'd0;
               resp_err   <= 1'b0;
               stall      <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: two LSUs (MEM_LAT=1 and MEM_LAT=3) each backed by a small word memory.
module tb_load_store_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid1, req_valid3;
   logic        req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;

   logic        req_ready1, mem_read1, mem_write1, resp_valid1, resp_err1, stall1;
   logic [31:0] data_address1, data1, mem_out1, resp_rdata1;
   logic        req_ready3, mem_read3, mem_write3, resp_valid3, resp_err3, stall3;
   logic [31:0] data_address3, data3, mem_out3, resp_rdata3;

   load_store_unit #(.MEM_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .data_address(data_address1),
      .data(data1), .MemRead(mem_read1), .MemWrite(mem_write1), .MemOut(mem_out1),
      .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
      .stall(stall1));

   load_store_unit #(.MEM_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .data_address(data_address3),
      .data(data3), .MemRead(mem_read3), .MemWrite(mem_write3), .MemOut(mem_out3),
      .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_err(resp_err3),
      .stall(stall3));

   logic [31:0] mem1 [0:15];
   logic [31:0] mem3 [0:15];
   wire unused_hi = ^{data_address1[31:4], data_address3[31:4]};

   always @(posedge clk) if (mem_write1) mem1[data_address1[3:0]] <= data1;
   always @(posedge clk) if (mem_write3) mem3[data_address3[3:0]] <= data3;
   assign mem_out1 = mem1[data_address1[3:0]];
   assign mem_out3 = mem3[data_address3[3:0]];

   int wr3_total = 0;
   int overlap   = 0;
   always @(posedge clk) if (mem_write3) wr3_total <= wr3_total + 1;
   always @(posedge clk)
      if ((mem_read1 && mem_write1) || (mem_read3 && mem_write3)) overlap <= overlap + 1;

   logic        sel;
   logic        c_rd, c_wr, c_stall, c_ready, c_rv, c_err;
   logic [31:0] c_addr, c_data, c_rdata;
   assign c_rd    = sel ? mem_read3     : mem_read1;
   assign c_wr    = sel ? mem_write3    : mem_write1;
   assign c_stall = sel ? stall3        : stall1;
   assign c_ready = sel ? req_ready3    : req_ready1;
   assign c_rv    = sel ? resp_valid3   : resp_valid1;
   assign c_err   = sel ? resp_err3     : resp_err1;
   assign c_addr  = sel ? data_address3 : data_address1;
   assign c_data  = sel ? data3         : data1;
   assign c_rdata = sel ? resp_rdata3   : resp_rdata1;

   int n_cmp = 0;
   int n_err = 0;
   int lat, nrd, nwr, nst, nnr, w0;
   logic        done, got_err;
   logic [31:0] seen_wd, seen_wa, got_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request and measure it until resp_valid (bounded), then check the idle cycle after
   task automatic issue(input logic s, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      sel = s; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      if (s) req_valid3 = 1'b1; else req_valid1 = 1'b1;
      @(posedge clk); #1;
      req_valid1 = 1'b0; req_valid3 = 1'b0;
      req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_size = 2'b11;
      lat = 0; nrd = 0; nwr = 0; nst = 0; nnr = 0; done = 1'b0;
      seen_wd = 32'h0; seen_wa = 32'h0; got_rd = 32'h0; got_err = 1'b0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (c_rd) nrd++;
         if (c_wr) begin nwr++; seen_wd = c_data; seen_wa = c_addr; end
         if (c_stall) nst++;
         if (!c_ready) nnr++;
         if (c_rv) begin done = 1'b1; got_rd = c_rdata; got_err = c_err; end
      end
      chk("resp_seen", {31'd0, done}, 32'd1);
      @(negedge clk);
      chk("ready_after_resp", {31'd0, c_ready}, 32'd1);
      chk("rdata_cleared", c_rdata, 32'd0);
      chk("valid_cleared", {31'd0, c_rv}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; req_valid1 = 1'b0; req_valid3 = 1'b0;
      req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, req_ready1}, 32'd1);
      chk("rst_stall", {31'd0, stall1}, 32'd0);
      chk("rst_strobes", {30'd0, mem_read1, mem_write1}, 32'd0);
      chk("rst_resp", {30'd0, resp_valid1, resp_err1}, 32'd0);
      chk("rst_addr", data_address1, 32'd0);
      chk("rst_data", data1, 32'd0);
      chk("rst_rdata", resp_rdata1, 32'd0);
      @(negedge clk) rst = 1'b0;

      // Word store then word load, MEM_LAT=1
      issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      chk("wst_lat", lat, 32'd2);
      chk("wst_nwr", nwr, 32'd1);
      chk("wst_nrd", nrd, 32'd0);
      chk("wst_addr", seen_wa, 32'd4);
      chk("wst_data", seen_wd, 32'hDEADBEEF);
      chk("wst_rdata", got_rd, 32'd0);
      issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      chk("wld_lat", lat, 32'd2);
      chk("wld_rdata", got_rd, 32'hDEADBEEF);
      chk("wld_nwr", nwr, 32'd0);

      // Byte store read-modify-write
      issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
      issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB);
      chk("bst_lat", lat, 32'd3);
      chk("bst_nrd", nrd, 32'd1);
      chk("bst_nwr", nwr, 32'd1);
      chk("bst_data", seen_wd, 32'h11AB3344);

      // Sub-word loads from 0x11AB3344
      issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
      chk("lb_signed", got_rd, 32'hFFFFFFAB);
      issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
      chk("lb_unsigned", got_rd, 32'h000000AB);
      issue(1'b0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
      chk("lh_signed_hi", got_rd, 32'h000011AB);
      issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
      chk("lb_lane1", got_rd, 32'h00000033);

      // Halfword store into low lane, then signed halfword load of a negative value
      issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h12348001);
      chk("hst_data", seen_wd, 32'h11AB8001);
      issue(1'b0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
      chk("lh_signed_neg", got_rd, 32'hFFFF8001);
      issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
      chk("lh_unsigned", got_rd, 32'h00008001);

      // Misaligned word load
      issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_lat", lat, 32'd1);
      chk("mis_err", {31'd0, got_err}, 32'd1);
      chk("mis_rdata", got_rd, 32'd0);
      chk("mis_nrd", nrd, 32'd0);
`else
      chk("mis_lat", lat, 32'd2);
      chk("mis_err", {31'd0, got_err}, 32'd0);
      chk("mis_rdata", got_rd, 32'h11AB8001);
`endif

      // MEM_LAT=3 timing
      issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h55667788);
      chk("l3_wst_lat", lat, 32'd2);
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      chk("l3_lat", lat, 32'd4);
      chk("l3_nrd", nrd, 32'd3);
      chk("l3_stall", nst, 32'd4);
      chk("l3_notready", nnr, 32'd4);
      chk("l3_rdata", got_rd, 32'h55667788);
      issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h000000EE);
      chk("l3_bst_lat", lat, 32'd5);
      chk("l3_bst_data", seen_wd, 32'hEE667788);

      // Reset during READ of a byte store
      @(negedge clk);
      sel = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h11; req_wdata = 32'h000000CC; req_valid3 = 1'b1;
      @(posedge clk); #1 req_valid3 = 1'b0;
      @(negedge clk);
      chk("mid_in_read", {30'd0, mem_read3, stall3}, 32'd3);
      w0 = wr3_total;
      #2 rst = 1'b1;
      #1;
      chk("mid_strobes", {30'd0, mem_read3, mem_write3}, 32'd0);
      chk("mid_stall_ready", {30'd0, stall3, req_ready3}, 32'd1);
      chk("mid_addr_data", data_address3 | data3, 32'd0);
      chk("mid_resp", {30'd0, resp_valid3, resp_err3} | resp_rdata3, 32'd0);
      req_valid3 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      req_valid3 = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", {30'd0, stall3, req_ready3}, 32'd1);
      chk("post_rst_nowrite", wr3_total - w0, 32'd0);
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      chk("post_rst_mem", got_rd, 32'hEE667788);

      chk("strobe_overlap", overlap, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
